// File: rtl/sbox_pkg.sv
// sbox_pkg: shared table geometry and loader state encoding for the S-box loader.
package sbox_pkg;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

endpackage

// File: rtl/sbox_dpram.sv
// sbox_dpram: one sync write port, one registered read port; a read of the address being written returns the old word.
module sbox_dpram #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [1 << AW];

    // The memory itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd <= rst ? '0 : mem[ra];
    end

endmodule

// File: rtl/sbox_table_loader.sv
// sbox_table_loader: streams 256 bytes into a forward S-box and builds the inverse S-box in the same pass.
// Define SBOX_BIJECT_CHECK_EN to flag duplicate entries on err.
module sbox_table_loader
    import sbox_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [AW-1:0] a_in,
    output logic [DW-1:0] a_out,
    input  logic [DW-1:0] b_in,
    output logic [AW-1:0] b_out
);

    state_t        state;
    logic [AW-1:0] idx;
    logic          hs;

    assign ld_ready = state == LOAD;
    assign busy     = state == LOAD;
    assign done     = state == DONE;
    // A start in the same cycle as a beat discards the beat.
    assign hs       = ld_valid & ld_ready & ~start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else if (start) begin
            state <= LOAD;
            idx   <= '0;
        end else if (hs) begin
            idx <= idx + AW'(1);
            if (&idx) state <= DONE;
        end
    end

`ifdef SBOX_BIJECT_CHECK_EN
    logic [DEPTH-1:0] seen;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            seen <= '0;
            err  <= 1'b0;
        end else if (hs) begin
            if (seen[ld_data]) err <= 1'b1;
            seen[ld_data] <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    sbox_dpram #(.DW(DW), .AW(AW)) u_fwd (
        .clk (clk),
        .rst (rst),
        .we  (hs),
        .wa  (idx),
        .wd  (ld_data),
        .ra  (a_in),
        .rd  (a_out)
    );

    sbox_dpram #(.DW(AW), .AW(DW)) u_inv (
        .clk (clk),
        .rst (rst),
        .we  (hs),
        .wa  (ld_data),
        .wd  (idx),
        .ra  (b_in),
        .rd  (b_out)
    );

endmodule

// File: tb/tb_sbox_table_loader.sv
// tb_sbox_table_loader: directed bench for the S-box loader; lookup expectations flow through a scoreboard queue.
module tb_sbox_table_loader;

    logic       clk = 1'b0;
    logic       rst, start, ld_valid;
    logic [7:0] ld_data, a_in, b_in, a_out, b_out;
    logic       ld_ready, busy, done, err;

    int         checks = 0;
    int         failures = 0;
    int         hs_count;
    logic [7:0] tbl [256];

    typedef struct {
        string      tag;
        bit         sel_b;
        logic [7:0] exp;
    } exp_t;
    exp_t sbq[$];

`ifdef SBOX_BIJECT_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    sbox_table_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .a_in     (a_in),
        .a_out    (a_out),
        .b_in     (b_in),
        .b_out    (b_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] v, input bit gaps);
        bit got = 1'b0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            ld_valid = 1'b0;
            tick();
        end
        ld_valid = 1'b1;
        ld_data  = v;
        for (int t = 0; t < 8 && !got; t++) begin
            got = ld_ready;
            tick();
        end
        ld_valid = 1'b0;
        if (got) hs_count++;
        else begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=ld_ready_low expected=accept");
        end
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) send(tbl[i], gaps);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        hs_count = 0;
    endtask

    task automatic full_load(input bit gaps);
        pulse_start();
        send_range(0, 255, gaps);
    endtask

    task automatic pop_check;
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, e.sel_b ? b_out : a_out, e.exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [7:0] a, input logic [7:0] ea,
                          input logic [7:0] b, input logic [7:0] eb);
        a_in = a;
        b_in = b;
        sbq.push_back('{{tag, "_a"}, 1'b0, ea});
        sbq.push_back('{{tag, "_b"}, 1'b1, eb});
        tick();
        pop_check();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0; a_in = '0; b_in = '0;
        hs_count = 0;
        tick();
        tick();
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_a_out", a_out, 0);
        chk("rst_b_out", b_out, 0);
        rst = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_no_accept", ld_ready, 0);
        end
        ld_valid = 1'b0;
        chk("idle_busy", busy, 0);

        // Identity table, no stalls
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
        pulse_start();
        chk("load_busy", busy, 1);
        send_range(0, 254, 1'b0);
        chk("ident_done_early", done, 0);
        send(tbl[255], 1'b0);
        chk("ident_done", done, 1);
        chk("ident_busy_off", busy, 0);
        chk("ident_ready_off", ld_ready, 0);
        chk("ident_hs", hs_count, 256);
        lookup("ident_lk", 8'h37, 8'h37, 8'hC4, 8'hC4);

        // XOR table with random valid gaps
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i) ^ 8'hA5;
        full_load(1'b1);
        chk("xor_hs", hs_count, 256);
        chk("xor_done", done, 1);
        chk("xor_err", err, 0);
        lookup("xor_lk", 8'h00, 8'hA5, 8'hA5, 8'h00);
        lookup("xor_lk2", 8'h5C, 8'h5C ^ 8'hA5, 8'h3B, 8'h3B ^ 8'hA5);

        // Duplicate entry at index 10 repeating index 3
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
        tbl[3] = 8'h42;
        tbl[10] = 8'h42;
        pulse_start();
        send_range(0, 9, 1'b0);
        chk("dup_err_before", err, 0);
        send(tbl[10], 1'b0);
        chk("dup_err_rise", err, CHK_EN);
        send_range(11, 255, 1'b0);
        chk("dup_done", done, 1);
        chk("dup_err_held", err, CHK_EN);
        pulse_start();
        chk("dup_err_clear", err, 0);

        // Restart at beat 100 needs a full 256 beats again
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
        pulse_start();
        send_range(0, 99, 1'b0);
        pulse_start();
        chk("restart_busy", busy, 1);
        chk("restart_done", done, 0);
        send_range(0, 254, 1'b0);
        chk("restart_done_early", done, 0);
        send(tbl[255], 1'b0);
        chk("restart_done_late", done, 1);

        // Start coincident with a beat drops that beat
        pulse_start();
        send_range(0, 2, 1'b0);
        start = 1'b1;
        ld_valid = 1'b1;
        ld_data = 8'h77;
        tick();
        start = 1'b0;
        ld_valid = 1'b0;
        hs_count = 0;
        send_range(0, 254, 1'b0);
        chk("coinc_done_early", done, 0);
        send(tbl[255], 1'b0);
        chk("coinc_done", done, 1);
        chk("coinc_hs", hs_count, 256);

        // Reset mid-load aborts to IDLE
        pulse_start();
        send_range(0, 49, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ld_ready, 0);
        chk("abort_done", done, 0);
        tick();
        chk("abort_stays_idle", busy, 0);

        // Read-during-write returns old data, then new
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
        tbl[20] = 8'h11;
        full_load(1'b0);
        chk("rdw_preload_done", done, 1);
        pulse_start();
        send_range(0, 19, 1'b0);
        a_in = 8'd20;
        sbq.push_back('{"rdw_old", 1'b0, 8'h11});
        ld_valid = 1'b1;
        ld_data = 8'h99;
        tick();
        ld_valid = 1'b0;
        pop_check();
        sbq.push_back('{"rdw_new", 1'b0, 8'h99});
        tick();
        pop_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
